// File: rtl/dmem_wbuf_ctrl_if.sv
// Core-side data-port bundle: request strobes/address/store data toward the memory,
// registered load return, combinational stall and write-buffer occupancy back to the core.
interface dmem_wbuf_ctrl_if #(
  parameter int DATA_WIDTH        = 36,
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int WB_DEPTH          = 2
);
  logic [ADDRESS_BUS_WIDTH-1:0] i_data_addr;
  logic [DATA_WIDTH-1:0]        i_data_write;
  logic                         i_mem_write;
  logic                         i_mem_read;
  logic [DATA_WIDTH-1:0]        o_data_mem;
  logic                         o_rd_valid;
  logic                         o_stall;
  logic [$clog2(WB_DEPTH):0]    o_wb_count;

  modport master (
    output i_data_addr, i_data_write, i_mem_write, i_mem_read,
    input  o_data_mem, o_rd_valid, o_stall, o_wb_count
  );

  modport slave (
    input  i_data_addr, i_data_write, i_mem_write, i_mem_read,
    output o_data_mem, o_rd_valid, o_stall, o_wb_count
  );
endinterface

// File: rtl/dmem_wbuf_ctrl.sv
// Data RAM with a FIFO store buffer drained in load-free cycles; loads return 1 cycle after acceptance,
// stall only on a full buffer. DMEM_WB_FORWARD_EN: forward buffered stores to loads (else stall on a match).
module dmem_wbuf_ctrl #(
  parameter int DATA_WIDTH        = 36,
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int MEM_DEPTH         = 1024,
  parameter int WB_DEPTH          = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dmem_wbuf_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_BUS_WIDTH:0] LP_DEPTH = (ADDRESS_BUS_WIDTH+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]           LP_FULL  = CNT_W'(WB_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem    [MEM_DEPTH];
  logic [IDX_W-1:0]      r_wb_idx [WB_DEPTH];
  logic [DATA_WIDTH-1:0] r_wb_dat [WB_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_data_mem;
  logic                  r_rd_valid;

  logic                  w_is_store;
  logic                  w_is_load;
  logic                  w_in_range;
  logic                  w_full;
  logic                  w_hit;
  logic                  w_stall;
  logic                  w_enq;
  logic                  w_load_acc;
  logic                  w_deq;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_load_dat;
`ifdef DMEM_WB_FORWARD_EN
  logic [DATA_WIDTH-1:0] w_fwd_dat;
`endif

  assign w_is_store = bus.i_mem_write;
  assign w_is_load  = bus.i_mem_read & ~bus.i_mem_write;
  assign w_idx      = bus.i_data_addr[IDX_W-1:0];
  assign w_in_range = ({1'b0, bus.i_data_addr} < LP_DEPTH);
  assign w_full     = (r_count == LP_FULL);

  // Scan oldest to youngest so the final match left standing is the youngest store.
  always_comb begin
    w_hit = 1'b0;
`ifdef DMEM_WB_FORWARD_EN
    w_fwd_dat = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) && w_in_range &&
          (r_wb_idx[r_head + PTR_W'(k)] == w_idx)) begin
        w_hit = 1'b1;
`ifdef DMEM_WB_FORWARD_EN
        w_fwd_dat = r_wb_dat[r_head + PTR_W'(k)];
`endif
      end
    end
  end

`ifdef DMEM_WB_FORWARD_EN
  assign w_stall    = (w_is_store | w_is_load) & w_full;
  assign w_load_dat = w_hit ? w_fwd_dat : (w_in_range ? r_mem[w_idx] : '0);
`else
  assign w_stall    = ((w_is_store | w_is_load) & w_full) | (w_is_load & w_hit);
  assign w_load_dat = w_in_range ? r_mem[w_idx] : '0;
`endif

  // Out-of-range stores are acknowledged (no stall) but never enter the buffer.
  assign w_enq      = w_is_store & ~w_full & w_in_range;
  assign w_load_acc = w_is_load & ~w_stall;
  assign w_deq      = ~w_load_acc & (r_count != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_data_mem <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_load_acc;
      if (w_load_acc) begin
        r_data_mem <= w_load_dat;
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Buffer payload and RAM carry no reset; a load is never accepted in a drain cycle.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_wb_idx[r_tail] <= w_idx;
      r_wb_dat[r_tail] <= bus.i_data_write;
    end
    if (w_deq) begin
      r_mem[r_wb_idx[r_head]] <= r_wb_dat[r_head];
    end
  end

  assign bus.o_data_mem = r_data_mem;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_stall    = w_stall;
  assign bus.o_wb_count = r_count;

endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// Bench for dmem_wbuf_ctrl: fixed vector table, hand sequences, then random traffic vs. a queue model.
module tb_dmem_wbuf_ctrl;
  localparam int DW = 36;
  localparam int AW = 14;
  localparam int MD = 1024;
  localparam int WD = 2;
`ifdef DMEM_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_wbuf_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_BUS_WIDTH(AW), .WB_DEPTH(WD)) bus ();

  dmem_wbuf_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_BUS_WIDTH(AW), .MEM_DEPTH(MD), .WB_DEPTH(WD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: RAM image plus a FIFO of pending {index, data} stores.
  logic [DW-1:0] m_ram [MD];
  int            q_idx [$];
  logic [DW-1:0] q_dat [$];
  logic [DW-1:0] m_data = '0;
  bit            m_vld  = 1'b0;

  bit            e_stall, e_vld;
  logic [DW-1:0] e_data;
  logic [1:0]    e_cnt;
  logic          a_stall, a_vld;
  logic [DW-1:0] a_data;
  logic [1:0]    a_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            we;
    bit            re;
    bit            x_stall;
    bit            x_vld;
    logic [DW-1:0] x_data;
    logic [1:0]    x_cnt;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [DW-1:0] pv(input int i);
    if (i == 5) return 36'h123456789;
    return (DW'(i) * 36'h00000F00F) ^ 36'hA5A5A5A5A;
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we, input bit re,
                              input bit xs, input bit xv, input logic [DW-1:0] xd, input logic [1:0] xc);
    vec_t v;
    v.addr = a; v.wd = d; v.we = we; v.re = re;
    v.x_stall = xs; v.x_vld = xv; v.x_data = xd; v.x_cnt = xc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request cycle: drive, sample stall before the edge, advance model, sample outputs after the edge.
  task automatic step(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input bit we, input bit re);
    bit st, ld, inr, full, hit, acc;
    logic [DW-1:0] fwd;
    fwd  = '0;
    st   = we;
    ld   = re && !we;
    inr  = (int'(addr) < MD);
    full = (q_idx.size() == WD);
    hit  = 1'b0;
    for (int k = 0; k < q_idx.size(); k++) begin
      if (inr && q_idx[k] == int'(addr)) begin
        hit = 1'b1;
        fwd = q_dat[k];
      end
    end
    e_stall = ((st || ld) && full) || (!FWD && ld && hit);
    bus.i_data_addr  = addr;
    bus.i_data_write = wd;
    bus.i_mem_write  = we;
    bus.i_mem_read   = re;
    #2;
    a_stall = bus.o_stall;
    @(posedge clk);
    acc = ld && !e_stall;
    if (acc) begin
      if (FWD && hit) m_data = fwd;
      else if (inr)   m_data = m_ram[addr[9:0]];
      else            m_data = '0;
    end
    m_vld = acc;
    if (!acc && q_idx.size() > 0) begin
      m_ram[q_idx[0]] = q_dat[0];
      void'(q_idx.pop_front());
      void'(q_dat.pop_front());
    end
    if (st && !full && inr) begin
      q_idx.push_back(int'(addr));
      q_dat.push_back(wd);
    end
    #1;
    a_vld  = bus.o_rd_valid;
    a_data = bus.o_data_mem;
    a_cnt  = bus.o_wb_count;
    e_vld  = m_vld;
    e_data = m_data;
    e_cnt  = 2'(q_idx.size());
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".stall"}, a_stall, e_stall);
    chk({tag, ".vld"},   a_vld,   e_vld);
    chk({tag, ".data"},  a_data,  e_data);
    chk({tag, ".cnt"},   a_cnt,   e_cnt);
  endtask

  initial begin
    int nst;
    logic [63:0] rnd;
    logic [AW-1:0] ra;

    vecs[0]  = mk(14'd5,    '0,          0, 1, 0, 1, 36'h123456789, 2'd0);
    vecs[1]  = mk(14'd0,    '0,          0, 0, 0, 0, 36'h123456789, 2'd0);
    vecs[2]  = mk(14'd3,    36'h333,     1, 1, 0, 0, 36'h123456789, 2'd1);
    vecs[3]  = mk(14'd0,    '0,          0, 0, 0, 0, 36'h123456789, 2'd0);
    vecs[4]  = mk(14'd3,    '0,          0, 1, 0, 1, 36'h333,       2'd0);
    vecs[5]  = mk(14'h3FFF, '0,          0, 1, 0, 1, '0,            2'd0);
    vecs[6]  = mk(14'h3FFF, 36'hDEAD,    1, 0, 0, 0, '0,            2'd0);
    vecs[7]  = mk(14'd0,    '0,          0, 0, 0, 0, '0,            2'd0);
    vecs[8]  = mk(14'd1023, '0,          0, 1, 0, 1, pv(1023),      2'd0);
    vecs[9]  = mk(14'd20,   36'hA1,      1, 0, 0, 0, pv(1023),      2'd1);
    vecs[10] = mk(14'd21,   36'hA2,      1, 0, 0, 0, pv(1023),      2'd1);
    vecs[11] = mk(14'd30,   '0,          0, 1, 0, 1, pv(30),        2'd1);
    vecs[12] = mk(14'd31,   '0,          0, 1, 0, 1, pv(31),        2'd1);
    vecs[13] = mk(14'd22,   36'hA3,      1, 0, 0, 0, pv(31),        2'd1);
    vecs[14] = mk(14'd20,   '0,          0, 1, 0, 1, 36'hA1,        2'd1);
    vecs[15] = mk(14'd0,    '0,          0, 0, 0, 0, 36'hA1,        2'd0);
    vecs[16] = mk(14'd22,   '0,          0, 1, 0, 1, 36'hA3,        2'd0);
    vecs[17] = mk(14'd21,   '0,          0, 1, 0, 1, 36'hA2,        2'd0);

    bus.i_data_addr  = '0;
    bus.i_data_write = '0;
    bus.i_mem_write  = 1'b0;
    bus.i_mem_read   = 1'b0;
    #12 rst = 1'b0;
    #4;
    chk("reset.data",  bus.o_data_mem, '0);
    chk("reset.vld",   bus.o_rd_valid, 1'b0);
    chk("reset.cnt",   bus.o_wb_count, '0);
    chk("reset.stall", bus.o_stall,    1'b0);

    // Preload every RAM word through the store path.
    for (int i = 0; i < MD; i++) step(AW'(i), pv(i), 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("preload.cnt", a_cnt, 2'd0);

    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].re);
      chk($sformatf("vec%0d.stall", i), a_stall, vecs[i].x_stall);
      chk($sformatf("vec%0d.vld", i),   a_vld,   vecs[i].x_vld);
      chk($sformatf("vec%0d.data", i),  a_data,  vecs[i].x_data);
      chk($sformatf("vec%0d.cnt", i),   a_cnt,   vecs[i].x_cnt);
    end

    // Two stores to one address, then an immediate load of it.
    step(14'd10, 36'hAAA, 1'b1, 1'b0);
    step(14'd10, 36'hBBB, 1'b1, 1'b0);
    chk("raw.cnt_after_stores", a_cnt, 2'd1);
    nst = 0;
    for (int k = 0; k < 5; k++) begin
      step(14'd10, '0, 1'b0, 1'b1);
      if (!a_stall) break;
      chk("raw.vld_while_stalled", a_vld, 1'b0);
      nst++;
    end
    chk("raw.stall_cycles", DW'(nst), FWD ? DW'(0) : DW'(1));
    chk("raw.vld",  a_vld,  1'b1);
    chk("raw.data", a_data, 36'hBBB);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("raw.cnt_empty", a_cnt, 2'd0);
    step(14'd10, '0, 1'b0, 1'b1);
    chk("raw.ram_data", a_data, 36'hBBB);

    // Asynchronous reset with a store still pending in the buffer.
    step(14'd40, 36'h4040, 1'b1, 1'b0);
    step(14'd50, '0, 1'b0, 1'b1);
    chk("rst_mid.cnt_before", a_cnt, 2'd1);
    bus.i_mem_write = 1'b0;
    bus.i_mem_read  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.data", bus.o_data_mem, '0);
    chk("rst_mid.vld",  bus.o_rd_valid, 1'b0);
    chk("rst_mid.cnt",  bus.o_wb_count, '0);
    q_idx.delete();
    q_dat.delete();
    m_data = '0;
    m_vld  = 1'b0;
    #2 rst = 1'b0;
    step(14'd40, '0, 1'b0, 1'b1);
    chk("rst_mid.lost_store", a_data, pv(40));
    chk("rst_mid.cnt_after",  a_cnt,  2'd0);

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom, $urandom};
      if ($urandom_range(0, 15) < 14) ra = AW'(100 + $urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 1) ra = 14'h3FFF;
      else ra = AW'($urandom_range(MD, (1 << AW) - 1));
      step(ra, rnd[DW-1:0], ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
